// File: rtl/div_pkg.sv
// Shared definitions for the div_16d8 sharing controller.
// DIV_DW/DIV_SW : divider dividend / divisor widths
// div_tag_t     : per-sample tag {is_real, id, div0} kept in order with the divider
// Q_DIV0        : quotient the divider reports for a zero divisor
package div_pkg;
  localparam int DIV_DW  = 16;
  localparam int DIV_SW  = 8;
  localparam int TAG_IDW = 3;                 // wide enough for up to 8 requesters
  localparam logic [DIV_DW-1:0] Q_DIV0 = 16'hffff;

  // is_real=0 marks a bubble: the divider sampled with no operand loaded
  typedef struct packed {
    logic               is_real;
    logic [TAG_IDW-1:0] id;
    logic               div0;
  } div_tag_t;

  localparam int TAG_W = $bits(div_tag_t);
endpackage

// File: rtl/div_tag_fifo.sv
// Synchronous tag FIFO, one entry per divider sample still in flight.
// Ports: clk_sys/reset_sys (async high), flush (empties), push/din, pop/dout
// (dout is the oldest entry), count/full/empty status.
// A push into a full FIFO is taken only when a pop frees a slot in the same
// cycle; a pop on an empty FIFO is ignored.
module div_tag_fifo
  import div_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_sys,
  input  logic             reset_sys,
  input  logic             flush,
  input  logic             push,
  input  logic [TAG_W-1:0] din,
  input  logic             pop,
  output logic [TAG_W-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [TAG_W-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_sys or posedge reset_sys) begin
    if (reset_sys) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // storage needs no reset: entries are only read after being written
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/div_share_ctrl.sv
// Shares one free-running div_16d8 between NUM_REQ requesters.
// Ports:
//   clk_sys, reset_sys (async high), flush (1-cycle sync flush request)
//   req_valid/req_ready/req_divident/req_divisor : round-robin request side
//   rsp_valid/rsp_q/rsp_remain/rsp_div0          : one-hot result strobe + data
//   div_divident/div_divisor/div_reset_sync      : to the divider
//   div_in_valid/div_out_valid/div_q/div_remain  : from the divider
//   err_ovf/err_unf                              : sticky tag FIFO errors
module div_share_ctrl
  import div_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_sys,
  input  logic                      reset_sys,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DIV_DW-1:0] req_divident,
  input  logic [NUM_REQ*DIV_SW-1:0] req_divisor,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DIV_DW-1:0]         rsp_q,
  output logic [DIV_SW-1:0]         rsp_remain,
  output logic                      rsp_div0,
  output logic [DIV_DW-1:0]         div_divident,
  output logic [DIV_SW-1:0]         div_divisor,
  output logic                      div_reset_sync,
  input  logic                      div_in_valid,
  input  logic                      div_out_valid,
  input  logic [DIV_DW-1:0]         div_q,
  input  logic [DIV_SW-1:0]         div_remain,
  output logic                      err_ovf,
  output logic                      err_unf
);
  localparam int CW = $clog2(DEPTH + 1);

  // operand register
  logic              loaded;
  logic [ID_W-1:0]   op_id;
  logic [DIV_DW-1:0] op_dvd;
  logic [DIV_SW-1:0] op_dvs;
  logic [ID_W-1:0]   rr_ptr;

  logic [CW-1:0]     ff_count;
  logic              ff_full, ff_empty;
  logic [TAG_W-1:0]  ff_dout;
  div_tag_t          head, push_tag;

  logic              push, pop_eff, slot_free, has_room, grant;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  int                idx;

  // flush cycle ignores the divider strobes entirely
  assign push    = div_in_valid & ~flush;
  assign pop_eff = div_out_valid & ~ff_empty & ~flush;

  // the register frees up when empty or when the divider samples it this edge;
  // room counts the loaded operand, which will need a tag once sampled
  assign slot_free = ~loaded | div_in_valid;
  assign has_room  = (int'(ff_count) - int'(pop_eff) + int'(loaded)) < DEPTH;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign grant = ~flush & slot_free & has_room & win_found;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    push_tag         = '0;
    push_tag.is_real = loaded;
    push_tag.id      = TAG_IDW'(op_id);
    push_tag.div0    = (op_dvs == '0);
  end

  assign head         = div_tag_t'(ff_dout);
  assign div_divident = op_dvd;
  assign div_divisor  = op_dvs;

  div_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk_sys   (clk_sys),
    .reset_sys (reset_sys),
    .flush     (flush),
    .push      (push),
    .din       (push_tag),
    .pop       (pop_eff),
    .dout      (ff_dout),
    .count     (ff_count),
    .full      (ff_full),
    .empty     (ff_empty)
  );

  always_ff @(posedge clk_sys or posedge reset_sys) begin
    if (reset_sys) begin
      loaded         <= 1'b0;
      op_id          <= '0;
      op_dvd         <= '0;
      op_dvs         <= '0;
      rr_ptr         <= '0;
      rsp_valid      <= '0;
      rsp_q          <= '0;
      rsp_remain     <= '0;
      rsp_div0       <= 1'b0;
      div_reset_sync <= 1'b0;
      err_ovf        <= 1'b0;
      err_unf        <= 1'b0;
    end else begin
      div_reset_sync <= flush;
      rsp_valid      <= '0;
      if (flush) begin
        loaded <= 1'b0;
      end else begin
        if (grant) begin
          loaded <= 1'b1;
          op_id  <= win_id;
          op_dvd <= req_divident[DIV_DW*win_id +: DIV_DW];
          op_dvs <= req_divisor[DIV_SW*win_id +: DIV_SW];
          rr_ptr <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
        end else if (div_in_valid) begin
          loaded <= 1'b0;
        end
        // bubbles are popped silently; data fields hold until the next real result
        if (pop_eff && head.is_real) begin
          for (int i = 0; i < NUM_REQ; i++) rsp_valid[i] <= (int'(head.id) == i);
          rsp_q      <= div_q;
          rsp_remain <= div_remain;
          rsp_div0   <= head.div0;
        end
        if (push && ff_full && !pop_eff) err_ovf <= 1'b1;
        if (div_out_valid && ff_empty)   err_unf <= 1'b1;
      end
    end
  end
endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Round-robin arbiter and sequencer sharing one free-running div_16d8 (16-bit dividend / 8-bit divisor) between NUM_REQ image-pipeline requesters.
- Presents registered operands to the divider and captures them on each divider sample pulse (div_in_valid).
- Tracks in-flight operations in a tag FIFO and routes each result (div_out_valid) back to the requester that issued it.
- Also drives the divider's synchronous flush (reset_sync).

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DEPTH, 4, tag FIFO entries; must be at least the divider's maximum in-flight sample count
- ID_W, 2, requester index width, = clog2(NUM_REQ)

Ports:
- clk_sys  in  1  system clock
- reset_sys  in  1  asynchronous reset, active-high
- flush  in  1  synchronous flush request, 1-cycle pulse
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  one-hot accept; request taken when valid&ready
- req_divident  in  NUM_REQ*16  packed dividends, requester i at [16i+15:16i]
- req_divisor  in  NUM_REQ*8  packed divisors
- rsp_valid  out  NUM_REQ  one-hot result strobe, 1 cycle
- rsp_q  out  16  quotient
- rsp_remain  out  8  remainder
- rsp_div0  out  1  result came from divisor==0 (q is 16'hffff)
- div_divident  out  16  to divider
- div_divisor  out  8  to divider
- div_reset_sync  out  1  to divider synchronous high reset
- div_in_valid  in  1  divider samples operands on this cycle's edge
- div_out_valid  in  1  divider q/remain valid this cycle
- div_q  in  16  divider quotient
- div_remain  in  8  divider remainder
- err_ovf  out  1  sticky: push into full FIFO attempted
- err_unf  out  1  sticky: div_out_valid with empty FIFO

Behaviour:
- Reset values: all outputs 0; FIFO empty; RR pointer 0; operand register empty (loaded=0).
- Operand register holds {loaded, id, divident, divisor}; outputs div_divident/div_divisor are its data fields (0 when never loaded).
- Load: when loaded=0, or loaded=1 and div_in_valid=1 this cycle, and (fifo_count - pop + loaded) < DEPTH:
  - pick first req_valid at or after RR pointer, wrapping;
  - assert req_ready for the winner combinationally, latch operands next edge, RR pointer <- winner+1 mod NUM_REQ.
- Otherwise req_ready = 0.
- Capture: on div_in_valid=1, push tag {real=loaded, id, div0=(divisor==0)}, then clear loaded unless reloaded this cycle.
  - With loaded=0 a bubble tag (real=0) is still pushed, so FIFO order matches divider sample order.
- Pop: on div_out_valid=1, pop oldest tag.
  - If real=1: next cycle rsp_valid[id]=1 and rsp_q/rsp_remain/rsp_div0 registered from div_q/div_remain/tag.
  - Bubbles produce no strobe.
  - Result latency: 1 cycle after div_out_valid.
- Push and pop in the same cycle are both allowed; count unchanged.
  - Push into full FIFO without a simultaneous pop: drop the push, set err_ovf.
  - Pop on empty FIFO: ignore, set err_unf (covers the divider's first out_valid after reset before any capture).
- rsp_* data fields hold their last value when rsp_valid=0.
- Flush (highest priority):
  - div_reset_sync=1 for exactly 1 cycle, registered (cycle after flush);
  - FIFO emptied, loaded=0, pending strobes suppressed, req_ready=0 in the flush cycle;
  - err flags and RR pointer kept.
  - Same-cycle div_in_valid/div_out_valid ignored.
- Width rules: no arithmetic on data; divisor==0 is passed through unchanged.
- FIFO count is ID_W-independent, width clog2(DEPTH+1).

Decomposition:
- Shared package div_pkg: DIV_DW=16, DIV_SW=8, tag struct {real, id, div0}, localparam Q_DIV0=16'hffff.
- One sub-module: div_tag_fifo (synchronous FIFO, DEPTH entries, push/pop/count/full/empty, flush).

Test Plan:
- Single requester: req 0 issues 80/5, then 80/4, then 80/10 -> rsp_valid[0] three times with q=16,20,8, remain=0,0,0, in issue order.
- Four requesters all valid continuously -> grants strictly 0,1,2,3,0,..., one per div_in_valid; each rsp routed to the correct index, checked q*divisor+remain==dividend.
- Divisor 0: req 2 issues 123/0 -> rsp_valid[2]=1, rsp_q=16'hffff, rsp_div0=1.
- No requests for 3 sample periods, then req 1 issues 111/10 -> bubbles produce no strobes; rsp_valid[1] with q=11, remain=1.
- flush pulsed while two operations are in flight -> div_reset_sync high 1 cycle, no rsp_valid for flushed ops; next request 112/7 returns q=16, remain=0.
- Bench divider model emits div_out_valid before any div_in_valid -> err_unf=1, no rsp_valid; a DEPTH=2 build with a 3-deep divider model -> err_ovf=1.
